// File: rtl/myriadrf_tx_if.sv
// LMS6002D TX serializer: buffers 24-bit IQ samples in a small FIFO and emits
// each one as two 12-bit halves (upper with txiqsel=0, then lower with txiqsel=1).
module myriadrf_tx_if #(
    parameter int FIFO_AW = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    input  logic [23:0]      s_data_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    output logic [11:0]      txd,
    output logic             txiqsel,
    output logic             underrun_o,
    output logic [CNT_W-1:0] underrun_cnt_o
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    logic [23:0]        r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_ph;
    logic               r_primed;
    logic [23:0]        r_cur;
    logic [11:0]        r_txd;
    logic               r_txiqsel;
    logic               r_underrun;
    logic [CNT_W-1:0]   r_underrun_cnt;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [23:0]        w_head;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_push  = s_valid_i && !w_full;
    assign w_pop   = enable_i && !r_ph && !w_empty;
    assign w_head  = r_mem[r_rd_ptr];

    // NOTE: storage array has no reset; validity is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_ph           <= 1'b0;
            r_primed       <= 1'b0;
            r_cur          <= '0;
            r_txd          <= '0;
            r_txiqsel      <= 1'b0;
            r_underrun     <= 1'b0;
            r_underrun_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end

            r_underrun <= 1'b0;
            if (!enable_i) begin
                // Idle drops any pending low half but keeps FIFO contents.
                r_txd     <= '0;
                r_txiqsel <= 1'b0;
                r_ph      <= 1'b0;
                r_primed  <= 1'b0;
            end else if (!r_ph) begin
                r_ph      <= 1'b1;
                r_txiqsel <= 1'b0;
                if (!w_empty) begin
                    r_cur    <= w_head;
                    r_txd    <= w_head[23:12];
                    r_primed <= 1'b1;
                end else begin
                    // Zero sample keeps the two-cycle bus cadence going.
                    r_cur <= '0;
                    r_txd <= '0;
                    if (r_primed) begin
                        r_underrun <= 1'b1;
                        if (r_underrun_cnt != '1) begin
                            r_underrun_cnt <= r_underrun_cnt + 1'b1;
                        end
                    end
                end
            end else begin
                r_txd     <= r_cur[11:0];
                r_txiqsel <= 1'b1;
                r_ph      <= 1'b0;
            end
        end
    end

    assign s_ready_o      = !w_full;
    assign txd            = r_txd;
    assign txiqsel        = r_txiqsel;
    assign underrun_o     = r_underrun;
    assign underrun_cnt_o = r_underrun_cnt;

endmodule

// File: tb/tb_myriadrf_tx_if.sv
// Directed bench for myriadrf_tx_if with a 4-bit underrun counter so that
// saturation is reachable in a short run.
module tb_myriadrf_tx_if;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             enable_i;
    logic [23:0]      s_data_i;
    logic             s_valid_i;
    logic             s_ready_o;
    logic [11:0]      txd;
    logic             txiqsel;
    logic             underrun_o;
    logic [CNT_W-1:0] underrun_cnt_o;

    int n_err = 0;
    int n_chk = 0;

    myriadrf_tx_if #(.FIFO_AW(2), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .enable_i       (enable_i),
        .s_data_i       (s_data_i),
        .s_valid_i      (s_valid_i),
        .s_ready_o      (s_ready_o),
        .txd            (txd),
        .txiqsel        (txiqsel),
        .underrun_o     (underrun_o),
        .underrun_cnt_o (underrun_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge, then settle so outputs are sampled away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_chk++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_bus(input string tag, input logic [11:0] e_txd, input logic e_sel,
                             input logic e_und, input logic [CNT_W-1:0] e_cnt);
        check({tag, ".txd"}, 32'(txd), 32'(e_txd));
        check({tag, ".sel"}, 32'(txiqsel), 32'(e_sel));
        check({tag, ".und"}, 32'(underrun_o), 32'(e_und));
        check({tag, ".cnt"}, 32'(underrun_cnt_o), 32'(e_cnt));
    endtask

    task automatic push_disabled(input logic [23:0] data);
        s_data_i  = data;
        s_valid_i = 1'b1;
        tick();
        s_valid_i = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        enable_i  = 1'b0;
        s_data_i  = '0;
        s_valid_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_bus("reset", 12'h000, 1'b0, 1'b0, 4'd0);
        check("reset.ready", 32'(s_ready_o), 32'd1);

        // Idle enabled stream: zeros, toggling select, no underrun.
        enable_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_bus("idle", 12'h000, 1'(i % 2), 1'b0, 4'd0);
        end

        // Two samples back-to-back while enabled.
        s_data_i  = 24'hABC123;
        s_valid_i = 1'b1;
        tick();
        check_bus("b2b.e1", 12'h000, 1'b0, 1'b0, 4'd0);
        s_data_i = 24'h456DEF;
        tick();
        check_bus("b2b.e2", 12'h000, 1'b1, 1'b0, 4'd0);
        s_valid_i = 1'b0;
        tick(); check_bus("b2b.abc", 12'hABC, 1'b0, 1'b0, 4'd0);
        tick(); check_bus("b2b.123", 12'h123, 1'b1, 1'b0, 4'd0);
        tick(); check_bus("b2b.456", 12'h456, 1'b0, 1'b0, 4'd0);
        tick(); check_bus("b2b.def", 12'hDEF, 1'b1, 1'b0, 4'd0);
        tick(); check_bus("b2b.urun", 12'h000, 1'b0, 1'b1, 4'd1);
        tick(); check_bus("b2b.post", 12'h000, 1'b1, 1'b0, 4'd1);
        enable_i = 1'b0;
        tick(); check_bus("b2b.off", 12'h000, 1'b0, 1'b0, 4'd1);

        // Fill while disabled: four accepted, fifth refused.
        s_valid_i = 1'b1;
        s_data_i = 24'h111AAA; tick(); check("fill1.ready", 32'(s_ready_o), 32'd1);
        s_data_i = 24'h222BBB; tick(); check("fill2.ready", 32'(s_ready_o), 32'd1);
        s_data_i = 24'h333CCC; tick(); check("fill3.ready", 32'(s_ready_o), 32'd1);
        s_data_i = 24'h444DDD; tick(); check("fill4.ready", 32'(s_ready_o), 32'd0);
        s_data_i = 24'h555EEE; tick(); check("fill5.ready", 32'(s_ready_o), 32'd0);
        check_bus("fill.idle", 12'h000, 1'b0, 1'b0, 4'd1);
        s_valid_i = 1'b0;
        enable_i  = 1'b1;
        tick(); check_bus("drain.111", 12'h111, 1'b0, 1'b0, 4'd1);
        check("drain.ready", 32'(s_ready_o), 32'd1);
        tick(); check_bus("drain.aaa", 12'hAAA, 1'b1, 1'b0, 4'd1);
        tick(); check_bus("drain.222", 12'h222, 1'b0, 1'b0, 4'd1);
        tick(); check_bus("drain.bbb", 12'hBBB, 1'b1, 1'b0, 4'd1);
        tick(); check_bus("drain.333", 12'h333, 1'b0, 1'b0, 4'd1);
        tick(); check_bus("drain.ccc", 12'hCCC, 1'b1, 1'b0, 4'd1);
        tick(); check_bus("drain.444", 12'h444, 1'b0, 1'b0, 4'd1);
        tick(); check_bus("drain.ddd", 12'hDDD, 1'b1, 1'b0, 4'd1);
        enable_i = 1'b0;
        tick(); check_bus("drain.off", 12'h000, 1'b0, 1'b0, 4'd1);

        // Disable right after an upper half: lower half is dropped.
        push_disabled(24'hABC123);
        push_disabled(24'h456DEF);
        enable_i = 1'b1;
        tick(); check_bus("abort.abc", 12'hABC, 1'b0, 1'b0, 4'd1);
        enable_i = 1'b0;
        tick(); check_bus("abort.off1", 12'h000, 1'b0, 1'b0, 4'd1);
        tick(); check_bus("abort.off2", 12'h000, 1'b0, 1'b0, 4'd1);
        enable_i = 1'b1;
        tick(); check_bus("abort.456", 12'h456, 1'b0, 1'b0, 4'd1);
        tick(); check_bus("abort.def", 12'hDEF, 1'b1, 1'b0, 4'd1);
        enable_i = 1'b0;
        tick(); check_bus("abort.off3", 12'h000, 1'b0, 1'b0, 4'd1);

        // Starve a primed stream for 20 sample periods; counter saturates at 15.
        push_disabled(24'h789ABC);
        enable_i = 1'b1;
        tick(); check_bus("starve.789", 12'h789, 1'b0, 1'b0, 4'd1);
        tick(); check_bus("starve.abc", 12'hABC, 1'b1, 1'b0, 4'd1);
        for (int k = 1; k <= 20; k++) begin
            tick();
            check_bus("starve.start", 12'h000, 1'b0, 1'b1, 4'((k + 1 > 15) ? 15 : k + 1));
            tick();
            check_bus("starve.half", 12'h000, 1'b1, 1'b0, 4'((k + 1 > 15) ? 15 : k + 1));
        end
        enable_i = 1'b0;
        tick();

        // Reset mid-stream with three entries still queued.
        push_disabled(24'hA0A0A1);
        push_disabled(24'hB0B0B1);
        push_disabled(24'hC0C0C1);
        push_disabled(24'hD0D0D1);
        enable_i = 1'b1;
        tick(); check_bus("rst.pre", 12'hA0A, 1'b0, 1'b0, 4'd15);
        rst = 1'b1;
        tick();
        check_bus("rst.mid", 12'h000, 1'b0, 1'b0, 4'd0);
        check("rst.ready", 32'(s_ready_o), 32'd1);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_bus("rst.idle", 12'h000, 1'(i % 2), 1'b0, 4'd0);
        end
        check("rst.ready_idle", 32'(s_ready_o), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
